// File: rtl/gate_mon_pkg.sv
// rtl/gate_mon_pkg.sv - shared FSM encoding and saturating helper for the gate-drive monitor
package gate_mon_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_D1_ON  = 3'd1;
    localparam logic [2:0] ST_DEAD_A = 3'd2;
    localparam logic [2:0] ST_D2_ON  = 3'd3;
    localparam logic [2:0] ST_DEAD_B = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_D1_ON  = ST_D1_ON,
        S_DEAD_A = ST_DEAD_A,
        S_D2_ON  = ST_D2_ON,
        S_DEAD_B = ST_DEAD_B,
        S_FAULT  = ST_FAULT
    } state_t;

    // Counters up to 32 bits share this; callers pass their own all-ones ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_val);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to 0
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gate_drive_monitor.sv
// rtl/gate_drive_monitor.sv - gate-drive pair monitor: period/high/dead-time measurement and fault latches
module gate_drive_monitor
    import gate_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MIN_DEAD    = 3,
    parameter int SHOOT_LIMIT = 1
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             drv_1_in,
    input  logic             drv_2_in,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] dead_last,
    output logic             meas_valid,
    output logic             shoot_fault,
    output logic             dead_fault
);

    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF >> (32 - CNT_W);
    localparam logic [31:0] MIN_DEAD_L = 32'(MIN_DEAD);
    localparam logic [31:0] SHOOT_L    = 32'(SHOOT_LIMIT);

    logic             w_d1;
    logic             w_d2;
    logic             w_d1_rise;
    logic             w_both_hi;
    logic             w_both_lo;
    logic             w_shoot_det;
    logic             w_dead_upd;
    logic [CNT_W-1:0] w_dead_val;
    logic             w_dead_viol;
    logic             w_clr_ok;

    logic             r_d1_q;
    logic             r_armed;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    state_t           r_state;
    logic [CNT_W-1:0] r_dead_cnt;
    logic [CNT_W-1:0] r_both_cnt;
    logic [CNT_W-1:0] r_dead_last;
    logic             r_shoot_fault;
    logic             r_dead_fault;

    sync_2ff u_sync_d1 (.i_clk(clk_50), .i_rst(rst), .i_d(drv_1_in), .o_q(w_d1));
    sync_2ff u_sync_d2 (.i_clk(clk_50), .i_rst(rst), .i_d(drv_2_in), .o_q(w_d2));

    assign w_d1_rise   = w_d1 & ~r_d1_q;
    assign w_both_hi   = w_d1 & w_d2;
    assign w_both_lo   = ~w_d1 & ~w_d2;
    assign w_shoot_det = w_both_hi && (sat_inc(32'(r_both_cnt), CNT_MAX) >= SHOOT_L);

    // A commutation completes when the opposite driver turns on; a direct swap reports zero dead time.
    always_comb begin
        w_dead_upd = 1'b0;
        w_dead_val = '0;
        case (r_state)
            S_D1_ON:  if (!w_d1 && w_d2) w_dead_upd = 1'b1;
            S_DEAD_A: if (!w_d1 && w_d2) begin
                w_dead_upd = 1'b1;
                w_dead_val = r_dead_cnt;
            end
            S_D2_ON:  if (w_d1 && !w_d2) w_dead_upd = 1'b1;
            S_DEAD_B: if (w_d1 && !w_d2) begin
                w_dead_upd = 1'b1;
                w_dead_val = r_dead_cnt;
            end
            default: ;
        endcase
    end

    assign w_dead_viol = w_dead_upd && (32'(w_dead_val) < MIN_DEAD_L);
    assign w_clr_ok    = fault_clr && !w_both_hi && !w_shoot_det && !w_dead_viol;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_d1_q       <= 1'b0;
            r_armed      <= 1'b0;
            r_per_cnt    <= '0;
            r_high_cnt   <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
        end else begin
            r_d1_q       <= w_d1;
            r_meas_valid <= 1'b0;
            if (w_d1_rise) begin
                // The edge cycle itself is high and belongs to the new period.
                r_per_cnt  <= '0;
                r_high_cnt <= CNT_W'(1);
                r_armed    <= 1'b1;
                if (r_armed) begin
                    r_period     <= CNT_W'(sat_inc(32'(r_per_cnt), CNT_MAX));
                    r_high_time  <= r_high_cnt;
                    r_meas_valid <= 1'b1;
                end
            end else begin
                r_per_cnt <= CNT_W'(sat_inc(32'(r_per_cnt), CNT_MAX));
                if (w_d1) begin
                    r_high_cnt <= CNT_W'(sat_inc(32'(r_high_cnt), CNT_MAX));
                end
            end
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_dead_cnt    <= '0;
            r_both_cnt    <= '0;
            r_dead_last   <= '0;
            r_shoot_fault <= 1'b0;
            r_dead_fault  <= 1'b0;
        end else begin
            r_both_cnt <= w_both_hi ? CNT_W'(sat_inc(32'(r_both_cnt), CNT_MAX)) : '0;

            if (w_shoot_det) begin
                r_shoot_fault <= 1'b1;
            end else if (w_clr_ok) begin
                r_shoot_fault <= 1'b0;
            end

            if (w_dead_viol) begin
                r_dead_fault <= 1'b1;
            end else if (w_clr_ok) begin
                r_dead_fault <= 1'b0;
            end

            if (w_dead_upd) begin
                r_dead_last <= w_dead_val;
            end

            if (w_shoot_det) begin
                r_state <= S_FAULT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_d1) begin
                            r_state <= S_D1_ON;
                        end else if (w_d2) begin
                            r_state <= S_D2_ON;
                        end
                    end
                    S_D1_ON: begin
                        if (!w_d1 && w_d2) begin
                            r_state <= S_D2_ON;
                        end else if (w_both_lo) begin
                            r_state    <= S_DEAD_A;
                            r_dead_cnt <= CNT_W'(1);
                        end
                    end
                    S_DEAD_A: begin
                        if (w_d1 && !w_d2) begin
                            r_state <= S_D1_ON;
                        end else if (!w_d1 && w_d2) begin
                            r_state <= S_D2_ON;
                        end else if (w_both_lo) begin
                            r_dead_cnt <= CNT_W'(sat_inc(32'(r_dead_cnt), CNT_MAX));
                        end
                    end
                    S_D2_ON: begin
                        if (w_d1 && !w_d2) begin
                            r_state <= S_D1_ON;
                        end else if (w_both_lo) begin
                            r_state    <= S_DEAD_B;
                            r_dead_cnt <= CNT_W'(1);
                        end
                    end
                    S_DEAD_B: begin
                        if (!w_d1 && w_d2) begin
                            r_state <= S_D2_ON;
                        end else if (w_d1 && !w_d2) begin
                            r_state <= S_D1_ON;
                        end else if (w_both_lo) begin
                            r_dead_cnt <= CNT_W'(sat_inc(32'(r_dead_cnt), CNT_MAX));
                        end
                    end
                    S_FAULT: begin
                        if (fault_clr && w_both_lo) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign period      = r_period;
    assign high_time   = r_high_time;
    assign dead_last   = r_dead_last;
    assign meas_valid  = r_meas_valid;
    assign shoot_fault = r_shoot_fault;
    assign dead_fault  = r_dead_fault;

endmodule

// File: tb/tb_gate_drive_monitor.sv
// tb/tb_gate_drive_monitor.sv - scoreboard bench for gate_drive_monitor
module tb_gate_drive_monitor;
    import gate_mon_pkg::*;

    logic        clk_50 = 1'b0;
    logic        rst = 1'b1;
    logic        drv_1_in = 1'b0;
    logic        drv_2_in = 1'b0;
    logic        fault_clr = 1'b0;
    logic [15:0] period;
    logic [15:0] high_time;
    logic [15:0] dead_last;
    logic        meas_valid;
    logic        shoot_fault;
    logic        dead_fault;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    int          m_tot = 0;
    int          m_hi = 0;
    logic        m_armed = 1'b0;
    logic        m_last_d1 = 1'b0;

    gate_drive_monitor #(.CNT_W(16), .MIN_DEAD(3), .SHOOT_LIMIT(1)) dut (
        .clk_50(clk_50), .rst(rst), .drv_1_in(drv_1_in), .drv_2_in(drv_2_in),
        .fault_clr(fault_clr), .period(period), .high_time(high_time),
        .dead_last(dead_last), .meas_valid(meas_valid),
        .shoot_fault(shoot_fault), .dead_fault(dead_fault)
    );

    always #5 clk_50 = ~clk_50;

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive pins for n cycles; a drv_1 rising edge closes the previous period in the model.
    task automatic step(input logic a, input logic b, input logic c, input int n);
        if (a && !m_last_d1) begin
            if (m_armed) exp_q.push_back({sat16(m_tot), sat16(m_hi)});
            m_armed = 1'b1;
            m_tot = 0;
            m_hi = 0;
        end
        m_last_d1 = a;
        drv_1_in = a;
        drv_2_in = b;
        fault_clr = c;
        repeat (n) @(negedge clk_50);
        m_tot += n;
        if (a) m_hi += n;
    endtask

    task automatic pwm(input int hi, input int dead_a, input int lo, input int dead_b);
        step(1'b1, 1'b0, 1'b0, hi);
        step(1'b0, 1'b0, 1'b0, dead_a);
        step(1'b0, 1'b1, 1'b0, lo);
        step(1'b0, 1'b0, 1'b0, dead_b);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv_1_in = 1'b0;
        drv_2_in = 1'b0;
        fault_clr = 1'b0;
        repeat (4) @(negedge clk_50);
        rst = 1'b0;
        m_armed = 1'b0;
        m_last_d1 = 1'b0;
        m_tot = 0;
        m_hi = 0;
    endtask

    always @(negedge clk_50) begin
        if (meas_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL meas_unexpected: got period %0d high %0d, expected no pulse", period, high_time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("meas_period", 32'(period), 32'(e[31:16]));
                check("meas_high", 32'(high_time), 32'(e[15:0]));
            end
        end
    end

    initial begin
        repeat (4) @(negedge clk_50);
        check("rst_period", 32'(period), 0);
        check("rst_high", 32'(high_time), 0);
        check("rst_dead_last", 32'(dead_last), 0);
        check("rst_meas_valid", 32'(meas_valid), 0);
        check("rst_shoot", 32'(shoot_fault), 0);
        check("rst_dead_fault", 32'(dead_fault), 0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 3);

        for (int i = 0; i < 4; i++) begin
            pwm(40, 3, 54, 3);
            if (i == 2) begin
                check("nom_period", 32'(period), 100);
                check("nom_high", 32'(high_time), 40);
            end
        end
        check("nom_dead_last", 32'(dead_last), 3);
        check("nom_shoot", 32'(shoot_fault), 0);
        check("nom_dead_fault", 32'(dead_fault), 0);

        pwm(40, 2, 55, 3);
        check("viol_dead_last", 32'(dead_last), 2);
        check("viol_dead_fault", 32'(dead_fault), 1);
        step(1'b0, 1'b0, 1'b0, 4);
        step(1'b0, 1'b0, 1'b1, 1);
        check("viol_cleared", 32'(dead_fault), 0);
        step(1'b0, 1'b0, 1'b0, 2);

        step(1'b1, 1'b1, 1'b0, 1);
        step(1'b0, 1'b0, 1'b0, 6);
        check("shoot_set", 32'(shoot_fault), 1);
        check("shoot_state", 32'(dut.r_state), 32'(ST_FAULT));
        check("shoot_dead_frozen", 32'(dead_last), 2);
        step(1'b1, 1'b1, 1'b0, 5);
        step(1'b1, 1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 1'b0, 3);
        check("shoot_clr_ignored", 32'(shoot_fault), 1);
        check("shoot_state_held", 32'(dut.r_state), 32'(ST_FAULT));
        step(1'b0, 1'b0, 1'b0, 5);
        step(1'b0, 1'b0, 1'b1, 1);
        check("shoot_cleared", 32'(shoot_fault), 0);
        check("shoot_idle", 32'(dut.r_state), 32'(ST_IDLE));
        step(1'b0, 1'b0, 1'b0, 3);

        step(1'b1, 1'b0, 1'b0, 30);
        step(1'b0, 1'b0, 1'b0, 2);
        step(1'b1, 1'b0, 1'b0, 30);
        step(1'b0, 1'b0, 1'b0, 5);
        check("glitch_dead_last", 32'(dead_last), 2);
        check("glitch_dead_fault", 32'(dead_fault), 0);
        check("glitch_period", 32'(period), 32);

        step(1'b1, 1'b0, 1'b0, 70000);
        step(1'b0, 1'b0, 1'b0, 3);
        step(1'b0, 1'b1, 1'b0, 5);
        step(1'b0, 1'b0, 1'b0, 3);
        step(1'b1, 1'b0, 1'b0, 10);
        step(1'b0, 1'b0, 1'b0, 5);
        check("sat_period", 32'(period), 65535);
        check("sat_high", 32'(high_time), 65535);
        check("sat_dead_last", 32'(dead_last), 3);

        step(1'b1, 1'b0, 1'b0, 20);
        step(1'b0, 1'b0, 1'b0, 10);
        do_reset();
        check("mid_rst_period", 32'(period), 0);
        check("mid_rst_dead_last", 32'(dead_last), 0);
        step(1'b1, 1'b0, 1'b0, 20);
        step(1'b0, 1'b0, 1'b0, 30);
        step(1'b1, 1'b0, 1'b0, 20);
        step(1'b0, 1'b0, 1'b0, 5);
        check("rearm_period", 32'(period), 50);
        check("rearm_high", 32'(high_time), 20);

        step(1'b0, 1'b0, 1'b0, 10);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
